ram_1r1w_bm: RTL and testbench

Parametrised simple-dual-port RAM (one read port, one write port) with per-byte write mask, read enable and valid, optional output register and optional hardware clear-on-reset sweep. It is the general storage primitive for caches, tag arrays and register-file-style buffers in the core. A read of an address written in the same cycle returns the merged new data.

---
 rtl/ram_1r1w_bm.sv | 127 ++++++++++++
 tb/tb_ram_1r1w_bm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_bm.sv
// Simple-dual-port RAM with per-byte write mask, optional output register
// and optional zeroing sweep after reset.
module ram_1r1w_bm #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned ADDR_W       = $clog2(DEPTH),
    parameter int unsigned BYTE_W       = 8,
    parameter int unsigned OUT_REG      = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rd,
    output logic                       rvalid,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wr,
    input  logic [DATA_W/BYTE_W-1:0]   wmask
);

    localparam int unsigned        LANES   = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]    DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ready;
    logic                raddr_ok, waddr_ok;
    logic                wr_fire, rd_fire;
    logic [DATA_W-1:0]   rword, merged;
    logic [DATA_W-1:0]   rd_q;
    logic                rv_q;

    assign ready     = (state == READY);
    assign init_done = ready;

    always_comb begin
        state_nx = state;
        case (state)
            RESET:   state_nx = (CLEAR_ON_RST != 0) ? CLEAR : READY;
            CLEAR:   if (cnt == LAST) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
        end
    end

    // Read word with same-cycle write merged in per lane (write-first).
    always_comb begin
        raddr_ok = ({1'b0, raddr} < DEPTH_X);
        waddr_ok = ({1'b0, waddr} < DEPTH_X);
        wr_fire  = ready && we && waddr_ok;
        rd_fire  = ready && re;
        rword    = raddr_ok ? mem[raddr] : '0;
        merged   = rword;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_fire && (waddr == raddr) && wmask[i])
                merged[i*BYTE_W +: BYTE_W] = wr[i*BYTE_W +: BYTE_W];
        end
    end

    // Array has no reset of its own; the sweep zeroes it word by word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_fire) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (wmask[i])
                        mem[waddr][i*BYTE_W +: BYTE_W] <= wr[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_fire;
            if (rd_fire)
                rd_q <= merged;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] rd_q2;
            logic              rv_q2;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_q2 <= '0;
                    rv_q2 <= 1'b0;
                end else begin
                    rv_q2 <= rv_q;
                    if (rv_q)
                        rd_q2 <= rd_q;
                end
            end

            assign rd     = rd_q2;
            assign rvalid = rv_q2;
        end else begin : g_noreg
            assign rd     = rd_q;
            assign rvalid = rv_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_1r1w_bm.sv
// Directed bench: three RAM variants share one stimulus stream and are checked
// against hand-computed values.
module tb_ram_1r1w_bm;

    logic        clk;
    logic        rst;
    logic        re, we;
    logic [3:0]  raddr, waddr;
    logic [63:0] wr;
    logic [7:0]  wmask;

    logic        d0, d1, d2;
    logic        rv0, rv1, rv2;
    logic [63:0] rd0, rd1, rd2;

    int checks = 0;
    int errors = 0;

    ram_1r1w_bm #(.DATA_W(64), .DEPTH(16), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .init_done(d0), .re(re), .raddr(raddr), .rd(rd0), .rvalid(rv0),
        .we(we), .waddr(waddr), .wr(wr), .wmask(wmask));

    ram_1r1w_bm #(.DATA_W(64), .DEPTH(16), .BYTE_W(8), .OUT_REG(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .init_done(d1), .re(re), .raddr(raddr), .rd(rd1), .rvalid(rv1),
        .we(we), .waddr(waddr), .wr(wr), .wmask(wmask));

    ram_1r1w_bm #(.DATA_W(64), .DEPTH(12), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst), .init_done(d2), .re(re), .raddr(raddr), .rd(rd2), .rvalid(rv2),
        .we(we), .waddr(waddr), .wr(wr), .wmask(wmask));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
        we = 1'b1; waddr = a; wr = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    // Single read: u0/u2 answer after one edge, u1 after two.
    task automatic rd_check(input string tag, input logic [3:0] a,
                            input logic [63:0] e16, input logic [63:0] e12);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
        chk({tag, "_rd0"}, rd0, e16);
        chk({tag, "_rv0"}, {63'd0, rv0}, 64'd1);
        chk({tag, "_rd2"}, rd2, e12);
        chk({tag, "_rv2"}, {63'd0, rv2}, 64'd1);
        chk({tag, "_rv1_early"}, {63'd0, rv1}, 64'd0);
        tick();
        chk({tag, "_rd1"}, rd1, e16);
        chk({tag, "_rv1"}, {63'd0, rv1}, 64'd1);
        chk({tag, "_rv0_drop"}, {63'd0, rv0}, 64'd0);
    endtask

    initial begin
        int r0, r1, r2, bad;

        rst = 1'b0; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; wr = '0; wmask = '0;
        repeat (3) tick();
        chk("rst_done0", {63'd0, d0}, 64'd0);
        chk("rst_done1", {63'd0, d1}, 64'd0);
        chk("rst_done2", {63'd0, d2}, 64'd0);
        chk("rst_rv0", {63'd0, rv0}, 64'd0);
        chk("rst_rv1", {63'd0, rv1}, 64'd0);
        chk("rst_rd0", rd0, 64'd0);
        chk("rst_rd1", rd1, 64'd0);
        chk("rst_rd2", rd2, 64'd0);

        // First sweep; reads attempted while clearing must not produce rvalid.
        rst = 1'b1;
        tick();
        r0 = 0; r1 = 0; r2 = 0; bad = 0;
        for (int n = 1; n <= 20; n++) begin
            re = (n < 10); raddr = 4'd0;
            tick();
            if (rv0 || rv1 || rv2) bad++;
            if (d0 && r0 == 0) r0 = n;
            if (d1 && r1 == 0) r1 = n;
            if (d2 && r2 == 0) r2 = n;
        end
        re = 1'b0;
        chk("sweep_rise0", 64'(r0), 64'd16);
        chk("sweep_rise1", 64'(r1), 64'd16);
        chk("sweep_rise2", 64'(r2), 64'd12);
        chk("sweep_no_rvalid", 64'(bad), 64'd0);

        rd_check("clr0", 4'd0, 64'd0, 64'd0);
        rd_check("clr9", 4'd9, 64'd0, 64'd0);
        rd_check("clr15", 4'd15, 64'd0, 64'd0);

        // Out of range for the 12-deep variant: dropped write, zero read.
        wr_word(4'd13, 64'hFF, 8'hFF);
        rd_check("oor13", 4'd13, 64'hFF, 64'd0);
        rd_check("oor1", 4'd1, 64'd0, 64'd0);

        wr_word(4'd5, 64'h1122334455667788, 8'hFF);
        wr_word(4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd_check("mask5", 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
        wr_word(4'd5, 64'h0, 8'h00);
        rd_check("mask0", 4'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);

        re = 1'b1; raddr = 4'd7;
        we = 1'b1; waddr = 4'd7; wr = 64'hDEADBEEFCAFEF00D; wmask = 8'hF0;
        tick();
        re = 1'b0; we = 1'b0;
        chk("coll_rd0", rd0, 64'hDEADBEEF00000000);
        chk("coll_rv0", {63'd0, rv0}, 64'd1);
        chk("coll_rd2", rd2, 64'hDEADBEEF00000000);
        tick();
        chk("coll_rd1", rd1, 64'hDEADBEEF00000000);
        chk("coll_rv1", {63'd0, rv1}, 64'd1);
        rd_check("coll7b", 4'd7, 64'hDEADBEEF00000000, 64'hDEADBEEF00000000);

        wr_word(4'd1, 64'h1, 8'hFF);
        wr_word(4'd2, 64'h2, 8'hFF);
        wr_word(4'd3, 64'h3, 8'hFF);
        re = 1'b1; raddr = 4'd1;
        tick();
        chk("pipe_e1_rv1", {63'd0, rv1}, 64'd0);
        chk("pipe_e1_rd0", rd0, 64'h1);
        raddr = 4'd2;
        tick();
        chk("pipe_e2_rd1", rd1, 64'h1);
        chk("pipe_e2_rv1", {63'd0, rv1}, 64'd1);
        chk("pipe_e2_rd0", rd0, 64'h2);
        raddr = 4'd3;
        tick();
        re = 1'b0;
        chk("pipe_e3_rd1", rd1, 64'h2);
        chk("pipe_e3_rv1", {63'd0, rv1}, 64'd1);
        tick();
        chk("pipe_e4_rd1", rd1, 64'h3);
        chk("pipe_e4_rv1", {63'd0, rv1}, 64'd1);
        chk("pipe_e4_rv0", {63'd0, rv0}, 64'd0);
        tick();
        chk("pipe_e5_rv1", {63'd0, rv1}, 64'd0);
        chk("pipe_e5_hold1", rd1, 64'h3);
        chk("pipe_e5_hold0", rd0, 64'h3);

        // Reset mid-sweep, then a full restart from address 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        repeat (8) tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_done0", {63'd0, d0}, 64'd0);
        chk("mid_rst_rv0", {63'd0, rv0}, 64'd0);
        rst = 1'b1;
        tick();
        r0 = 0; r1 = 0; r2 = 0; bad = 0;
        for (int n = 1; n <= 20; n++) begin
            re = (n == 5); we = (n == 5);
            raddr = 4'd2; waddr = 4'd2; wr = '1; wmask = 8'hFF;
            tick();
            if (rv0 || rv1 || rv2) bad++;
            if (d0 && r0 == 0) r0 = n;
            if (d1 && r1 == 0) r1 = n;
            if (d2 && r2 == 0) r2 = n;
        end
        re = 1'b0; we = 1'b0;
        chk("mid_rise0", 64'(r0), 64'd16);
        chk("mid_rise1", 64'(r1), 64'd16);
        chk("mid_rise2", 64'(r2), 64'd12);
        chk("mid_no_rvalid", 64'(bad), 64'd0);
        rd_check("mid2", 4'd2, 64'd0, 64'd0);
        rd_check("mid5", 4'd5, 64'd0, 64'd0);
        rd_check("mid13", 4'd13, 64'd0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
